rr_mux16_arbiter: RTL

Round-robin arbiter that shares one N-bit 16:1 datapath mux among 16 requesters.
- Each requester presents a request bit and an N-bit word.
- The arbiter picks a winner fairly and steers the mux select to it.
- It registers the selected word and hands it downstream over a valid/ready handshake, returning a one-hot ack to the winning requester.
- Sits between 16 producer lanes and a single shared consumer.

---
 rtl/rr_mux16_arbiter_pkg.sv | 16 +
 rtl/mux16x1N.sv | 16 +
 rtl/rr_mux16_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rr_mux16_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 16-lane round-robin arbiter.
package rr_mux16_arbiter_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        sel_onehot = NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux16x1N.sv
// Plain 16:1 mux of N-bit lanes; lane i lives at din[i*N +: N].
module mux16x1N
    import rr_mux16_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM_REQ*N-1:0] din,
    output logic [N-1:0]         dout
);

    always_comb begin
        dout = din[32'(sel) * N +: N];
    end

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter steering a shared 16:1 lane mux into a registered
// valid/ready output stage, with a combinational one-hot ack to the winner.
module rr_mux16_arbiter
    import rr_mux16_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] din,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic [NUM_REQ-1:0]   ack
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N-1:0]      data_q, data_d;

    logic              handshake;
    logic [SEL_W-1:0]  base;
    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W-1:0]  win_idx;
    logic [N-1:0]      win_data;

    // First set bit of vec scanning upward from base, wrapping 15 -> 0.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                                 input logic [SEL_W-1:0]   start);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && vec[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        handshake = (state_q == StBusy) && out_ready;
        base      = handshake ? sel_q + SEL_W'(1) : ptr_q;
        // The current winner still holds req during its ack cycle; mask it out.
        eligible  = handshake ? (req & ~sel_onehot(sel_q)) : req;
        win_idx   = rr_pick(eligible, base);
    end

    mux16x1N #(
        .N(N)
    ) u_mux (
        .sel (win_idx),
        .din (din),
        .dout(win_data)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StBusy;
                    sel_d   = win_idx;
                    data_d  = win_data;
                end
            end
            StBusy: begin
                if (out_ready) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (|eligible) begin
                        sel_d  = win_idx;
                        data_d = win_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StBusy);
        out_data  = data_q;
        out_sel   = sel_q;
        ack       = (out_valid && out_ready) ? sel_onehot(sel_q) : '0;
    end

endmodule
